// File: rtl/trace_pkg.sv
// Shared trace-record definitions: retirement kind codes and the packed record width.
package trace_pkg;

  localparam logic [2:0] KIND_NOP  = 3'd0;
  localparam logic [2:0] KIND_REG  = 3'd1;
  localparam logic [2:0] KIND_LD   = 3'd2;
  localparam logic [2:0] KIND_ST   = 3'd3;
  localparam logic [2:0] KIND_STU  = 3'd4;
  localparam logic [2:0] KIND_HALT = 3'd5;

  // Record layout, MSB first: {kind, inum, pc, reg, wdata, addr, mdata}
  function automatic int recWidth(input int pcW, input int dataW, input int addrW,
                                  input int regW, input int cntW);
    return 3 + cntW + pcW + regW + dataW + addrW + dataW;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with wrap-bit pointers; the head is readable combinationally when not empty.
// A push to a full FIFO is accepted only when a pop happens in the same cycle; clear empties it.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wrPtr, rdPtr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             doPush, doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign rdata  = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
      if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: nothing is visible until a pointer moves past it.
  always_ff @(posedge clk) begin
    if (doPush && !clear) mem[wrPtr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement trace monitor: classifies each commit, numbers it and queues it; record visible the
// cycle after the event. A full queue either stalls retirement or drops and counts the record.
module retire_trace_buffer
  import trace_pkg::*;
#(
  parameter int PC_W         = 16,
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 16,
  parameter int REG_W        = 3,
  parameter int DEPTH        = 16,
  parameter int CNT_W        = 32,
  parameter int BACKPRESSURE = 1,
  localparam int REC_W       = recWidth(PC_W, DATA_W, ADDR_W, REG_W, CNT_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              enable,
  input  logic              retire_valid,
  input  logic [PC_W-1:0]   pc,
  input  logic [PC_W-1:0]   inst,
  input  logic              reg_write,
  input  logic [REG_W-1:0]  write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              halt,
  output logic              retire_stall,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [REC_W-1:0]  trace_rec,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overflow,
  output logic              halted,
  output logic              drain_done
);

  logic              fifoFull, fifoEmpty;
  logic              pop, push, evt, drop;
  logic [2:0]        kind;
  logic [REG_W-1:0]  recReg;
  logic [DATA_W-1:0] recWdata, recMdata;
  logic [ADDR_W-1:0] recAddr;
  logic [REC_W-1:0]  rec;
  logic [CNT_W-1:0]  instQ, cycleQ, dropQ;
  logic              overflowQ, haltedQ;

  // The instruction word is not part of the record; it stays on the port for the commit tap.
  logic unusedInst;
  assign unusedInst = ^inst;

  assign retire_stall = (BACKPRESSURE != 0) && fifoFull;
  assign trace_valid  = !fifoEmpty;
  assign pop          = trace_valid && trace_ready;
  assign evt          = retire_valid && enable && !haltedQ && !retire_stall;
  assign push         = evt && (!fifoFull || pop);
  assign drop         = evt && fifoFull && !pop;

  always_comb begin
    kind     = KIND_NOP;
    recReg   = '0;
    recWdata = '0;
    recAddr  = '0;
    recMdata = '0;
    if (halt) begin
      kind = KIND_HALT;
    end else if (reg_write && mem_write) begin
      kind     = KIND_STU;
      recReg   = write_reg;
      recWdata = write_data;
      recAddr  = mem_addr;
      recMdata = mem_data;
    end else if (reg_write && mem_read) begin
      kind     = KIND_LD;
      recReg   = write_reg;
      recWdata = write_data;
      recAddr  = mem_addr;
    end else if (mem_write) begin
      kind     = KIND_ST;
      recAddr  = mem_addr;
      recMdata = mem_data;
    end else if (reg_write) begin
      kind     = KIND_REG;
      recReg   = write_reg;
      recWdata = write_data;
    end
  end

  assign rec = {kind, instQ, pc, recReg, recWdata, recAddr, recMdata};

  trace_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) traceFifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .wdata (rec),
    .pop   (pop),
    .rdata (trace_rec),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instQ     <= '0;
      cycleQ    <= '0;
      dropQ     <= '0;
      overflowQ <= 1'b0;
      haltedQ   <= 1'b0;
    end else if (clear) begin
      instQ     <= '0;
      cycleQ    <= '0;
      dropQ     <= '0;
      overflowQ <= 1'b0;
      haltedQ   <= 1'b0;
    end else begin
      // The HALT cycle itself still counts; the counter freezes from the next cycle on.
      if (!haltedQ) cycleQ <= cycleQ + CNT_W'(1);
      if (evt) begin
        instQ <= instQ + CNT_W'(1);
        if (halt) haltedQ <= 1'b1;
      end
      if (drop) begin
        overflowQ <= 1'b1;
        if (dropQ != '1) dropQ <= dropQ + CNT_W'(1);
      end
    end
  end

  assign inst_count  = instQ;
  assign cycle_count = cycleQ;
  assign drop_count  = dropQ;
  assign overflow    = overflowQ;
  assign halted      = haltedQ;
  assign drain_done  = haltedQ && fifoEmpty;

endmodule
